// File: rtl/gray_rx_decoder_if.sv
// rtl/gray_rx_decoder_if.sv - Gray sample input and decoded result/status bundle.
interface gray_rx_decoder_if #(
  parameter int DATA_WIDTH = 4,
  parameter int CNT_WIDTH  = 8
);
  logic [DATA_WIDTH-1:0] gray_in;
  logic                  gray_valid;
  logic [DATA_WIDTH-1:0] bin_out;
  logic                  bin_valid;
  logic                  step;
  logic                  hold;
  logic                  err;
  logic                  locked;
  logic [CNT_WIDTH-1:0]  err_count;

  modport master (
    output gray_in, gray_valid,
    input  bin_out, bin_valid, step, hold, err, locked, err_count
  );

  modport slave (
    input  gray_in, gray_valid,
    output bin_out, bin_valid, step, hold, err, locked, err_count
  );
endinterface

// File: rtl/gray_rx_decoder.sv
// rtl/gray_rx_decoder.sv - Gray-to-binary sample decoder with step checking and lock tracking.
module gray_rx_decoder #(
  parameter int DATA_WIDTH = 4,
  parameter int CNT_WIDTH  = 8,
  parameter int RELOCK     = 3
) (
  input  logic               clk,
  input  logic               reset,
  gray_rx_decoder_if.slave   rx
);
  localparam int RUN_W = 8;

  typedef enum logic [1:0] {S_EMPTY = 2'd0, S_LOCKED = 2'd1, S_FAULT = 2'd2} state_t;

  state_t                state_q, state_d;
  logic [RUN_W-1:0]      run_q, run_d;
  logic [DATA_WIDTH-1:0] prev_q, prev_d;
  logic [DATA_WIDTH-1:0] bin_out_q, bin_out_d;
  logic                  bin_valid_q, bin_valid_d;
  logic                  step_q, step_d;
  logic                  hold_q, hold_d;
  logic                  err_q, err_d;
  logic                  locked_q, locked_d;
  logic [CNT_WIDTH-1:0]  err_count_q, err_count_d;

  logic [DATA_WIDTH-1:0] bin_n;
  logic                  is_hold, is_step, is_err, classify;

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    bin_n = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      bin_n[i] = ^(rx.gray_in >> i);
    end
  end

  always_comb begin
    classify = rx.gray_valid && (state_q != S_EMPTY);
    is_hold  = classify && (bin_n == prev_q);
    is_step  = classify && (bin_n == prev_q + DATA_WIDTH'(1));
    is_err   = classify && !is_hold && !is_step;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_EMPTY;
      run_q       <= '0;
      prev_q      <= '0;
      bin_out_q   <= '0;
      bin_valid_q <= 1'b0;
      step_q      <= 1'b0;
      hold_q      <= 1'b0;
      err_q       <= 1'b0;
      locked_q    <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      prev_q      <= prev_d;
      bin_out_q   <= bin_out_d;
      bin_valid_q <= bin_valid_d;
      step_q      <= step_d;
      hold_q      <= hold_d;
      err_q       <= err_d;
      locked_q    <= locked_d;
      err_count_q <= err_count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    if (rx.gray_valid) begin
      case (state_q)
        S_EMPTY: state_d = S_LOCKED;
        S_LOCKED: begin
          if (is_err) begin
            state_d = S_FAULT;
            run_d   = '0;
          end
        end
        S_FAULT: begin
          if (is_err) begin
            run_d = '0;
          end else if (is_step) begin
            // run_q never exceeds RELOCK-1 here, so the increment cannot overflow.
            if (run_q + RUN_W'(1) == RUN_W'(RELOCK)) begin
              state_d = S_LOCKED;
              run_d   = '0;
            end else begin
              run_d = run_q + RUN_W'(1);
            end
          end
        end
        default: begin
          state_d = S_EMPTY;
          run_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    bin_valid_d = rx.gray_valid;
    bin_out_d   = rx.gray_valid ? bin_n : bin_out_q;
    prev_d      = rx.gray_valid ? bin_n : prev_q;
    step_d      = is_step;
    hold_d      = is_hold;
    err_d       = is_err;
    locked_d    = (state_d == S_LOCKED);
    err_count_d = err_count_q;
    if (is_err && (err_count_q != {CNT_WIDTH{1'b1}})) begin
      err_count_d = err_count_q + CNT_WIDTH'(1);
    end
  end

  assign rx.bin_out   = bin_out_q;
  assign rx.bin_valid = bin_valid_q;
  assign rx.step      = step_q;
  assign rx.hold      = hold_q;
  assign rx.err       = err_q;
  assign rx.locked    = locked_q;
  assign rx.err_count = err_count_q;
endmodule

// File: tb/tb_gray_rx_decoder.sv
// tb/tb_gray_rx_decoder.sv - Directed self-checking bench for gray_rx_decoder.
module tb_gray_rx_decoder;
  logic clk;
  logic reset;
  int   errors;
  int   checks;

  gray_rx_decoder_if #(.DATA_WIDTH(4), .CNT_WIDTH(2)) ifc ();

  gray_rx_decoder #(.DATA_WIDTH(4), .CNT_WIDTH(2), .RELOCK(2)) dut (
    .clk   (clk),
    .reset (reset),
    .rx    (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [3:0] g);
    reset          = r;
    ifc.gray_valid = v;
    ifc.gray_in    = g;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] bo, input logic bv, input logic st,
                         input logic hd, input logic er, input logic lk, input logic [1:0] ec);
    chk({tag, ".bin_out"},   8'(ifc.bin_out),   8'(bo));
    chk({tag, ".bin_valid"}, 8'(ifc.bin_valid), 8'(bv));
    chk({tag, ".step"},      8'(ifc.step),      8'(st));
    chk({tag, ".hold"},      8'(ifc.hold),      8'(hd));
    chk({tag, ".err"},       8'(ifc.err),       8'(er));
    chk({tag, ".locked"},    8'(ifc.locked),    8'(lk));
    chk({tag, ".err_count"}, 8'(ifc.err_count), 8'(ec));
  endtask

  initial begin
    logic [3:0] g;
    errors = 0;
    checks = 0;
    reset          = 1'b1;
    ifc.gray_valid = 1'b0;
    ifc.gray_in    = 4'b0000;

    // Reset and first sample
    drive(1'b1, 1'b0, 4'b0000);
    drive(1'b1, 1'b0, 4'b0000);
    chk_all("reset", 4'd0, 0, 0, 0, 0, 0, 2'd0);
    drive(1'b0, 1'b1, 4'b0000);
    chk_all("first", 4'd0, 1, 0, 0, 0, 1, 2'd0);

    // Normal count 1..4
    drive(1'b0, 1'b1, 4'b0001); chk_all("cnt1", 4'd1, 1, 1, 0, 0, 1, 2'd0);
    drive(1'b0, 1'b1, 4'b0011); chk_all("cnt2", 4'd2, 1, 1, 0, 0, 1, 2'd0);
    drive(1'b0, 1'b1, 4'b0010); chk_all("cnt3", 4'd3, 1, 1, 0, 0, 1, 2'd0);
    drive(1'b0, 1'b1, 4'b0110); chk_all("cnt4", 4'd4, 1, 1, 0, 0, 1, 2'd0);

    // Continue to 15 (last Gray code is 1000)
    for (int n = 5; n <= 15; n++) begin
      g = 4'(n) ^ (4'(n) >> 1);
      drive(1'b0, 1'b1, g);
      chk("count.step", 8'(ifc.step), 8'd1);
      chk("count.bin_out", 8'(ifc.bin_out), 8'(n));
    end
    chk("gray15", 8'(g), 8'b0000_1000);

    // Idle gap holds bin_out at 1111
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 4'b0101);
      chk_all("gap", 4'd15, 0, 0, 0, 0, 1, 2'd0);
    end
    drive(1'b0, 1'b1, 4'b0000); chk_all("wrap", 4'd0, 1, 1, 0, 0, 1, 2'd0);

    // Fault and relock with RELOCK=2
    drive(1'b0, 1'b1, 4'b0001); chk_all("pre1",   4'd1, 1, 1, 0, 0, 1, 2'd0);
    drive(1'b0, 1'b1, 4'b0010); chk_all("jump3",  4'd3, 1, 0, 0, 1, 0, 2'd1);
    drive(1'b0, 1'b1, 4'b0110); chk_all("run4",   4'd4, 1, 1, 0, 0, 0, 2'd1);
    drive(1'b0, 1'b1, 4'b0110); chk_all("hold4",  4'd4, 1, 0, 1, 0, 0, 2'd1);
    drive(1'b0, 1'b1, 4'b0111); chk_all("relock", 4'd5, 1, 0 | 1, 0, 0, 1, 2'd1);
    drive(1'b0, 1'b1, 4'b0111); chk_all("lhold",  4'd5, 1, 0, 1, 0, 1, 2'd1);
    drive(1'b0, 1'b1, 4'b0110); chk_all("back",   4'd4, 1, 0, 0, 1, 0, 2'd2);

    // Error saturation with CNT_WIDTH=2
    drive(1'b1, 1'b0, 4'b0000); chk_all("rst2", 4'd0, 0, 0, 0, 0, 0, 2'd0);
    drive(1'b0, 1'b1, 4'b0000); chk_all("sat0", 4'd0, 1, 0, 0, 0, 1, 2'd0);
    drive(1'b0, 1'b1, 4'b0011); chk_all("sat1", 4'd2, 1, 0, 0, 1, 0, 2'd1);
    drive(1'b0, 1'b1, 4'b0000); chk_all("sat2", 4'd0, 1, 0, 0, 1, 0, 2'd2);
    drive(1'b0, 1'b1, 4'b0011); chk_all("sat3", 4'd2, 1, 0, 0, 1, 0, 2'd3);
    drive(1'b0, 1'b1, 4'b0000); chk_all("sat4", 4'd0, 1, 0, 0, 1, 0, 2'd3);
    drive(1'b0, 1'b1, 4'b0011); chk_all("sat5", 4'd2, 1, 0, 0, 1, 0, 2'd3);

    // Reset mid-operation from FAULT with err_count=2
    drive(1'b1, 1'b0, 4'b0000);
    drive(1'b0, 1'b1, 4'b0000);
    drive(1'b0, 1'b1, 4'b0011);
    drive(1'b0, 1'b1, 4'b0000); chk_all("mid.fault", 4'd0, 1, 0, 0, 1, 0, 2'd2);
    drive(1'b1, 1'b1, 4'b0001); chk_all("mid.reset", 4'd0, 0, 0, 0, 0, 0, 2'd0);
    drive(1'b0, 1'b1, 4'b1100); chk_all("mid.first", 4'd8, 1, 0, 0, 0, 1, 2'd0);
    drive(1'b0, 1'b1, 4'b1101); chk_all("mid.step",  4'd9, 1, 1, 0, 0, 1, 2'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/gray_rx_decoder.md
Name: gray_rx_decoder

Overview:
- Receive-side counterpart of the team's Gray-code counter. Accepts a sampled Gray-coded count and decodes it to binary.
- Checks that consecutive samples are legal single-step advances.
- Tracks lock state, so downstream logic (pointer compare, rate measure) can trust the decoded value only while locked.

Parameters:
- DATA_WIDTH, 4: width of Gray input and binary output.
- CNT_WIDTH, 8: width of the saturating error counter.
- RELOCK, 3: consecutive legal +1 steps required to leave FAULT; legal range 1..255.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: synchronous, active-high reset.
- gray_in, input, DATA_WIDTH: Gray-coded sample.
- gray_valid, input, 1: gray_in is sampled on this edge.
- bin_out, output, DATA_WIDTH: registered binary decode of the last valid sample.
- bin_valid, output, 1: one-cycle pulse; bin_out updated this cycle.
- step, output, 1: one-cycle pulse; sample was previous+1 mod 2^DATA_WIDTH.
- hold, output, 1: one-cycle pulse; sample equals previous.
- err, output, 1: one-cycle pulse; illegal transition.
- locked, output, 1: level; state is LOCKED.
- err_count, output, CNT_WIDTH: saturating count of illegal transitions.

Behaviour:
- Reset (sampled on rising clk while reset=1):
  - All outputs go to 0; state goes to EMPTY; have_prev=0; relock run counter=0.
  - Reset dominates gray_valid on the same edge.
  - Reset mid-operation discards history; the next valid sample is treated as the first.
- Decode: b[MSB]=g[MSB]; b[i]=b[i+1] XOR g[i] down to bit 0. Pure combinational, registered once.
- Latency: gray_valid high at edge t gives bin_out, bin_valid and exactly one of {step, hold, err} (or none for a first sample) valid after edge t, i.e. during cycle t+1.
- gray_valid low at an edge:
  - bin_valid, step, hold and err go to 0.
  - bin_out, err_count, locked and state hold.
- Classification (new binary n vs stored prev, both DATA_WIDTH bits):
  - n == prev: hold.
  - n == prev+1, wrapping modulo 2^DATA_WIDTH (all-ones to zero is legal): step.
  - Anything else: err. This includes backward steps and multi-bit jumps.
  - prev is updated with n on every valid sample, including erroneous ones.
- State machine (states EMPTY, LOCKED, FAULT):
  - EMPTY, valid sample: store prev, go to LOCKED. No step, hold or err pulse is issued; bin_valid=1.
  - LOCKED:
    - step or hold: stay in LOCKED.
    - err: go to FAULT, pulse err, increment err_count, clear run counter.
  - FAULT:
    - step: run counter +1. When the run counter reaches RELOCK, go to LOCKED and clear the run counter.
    - hold: run counter unchanged, stay in FAULT.
    - err: pulse err, increment err_count, clear run counter, stay in FAULT.
- locked = 1 only in LOCKED. It is registered and changes in the same cycle as the corresponding bin_valid.
- err_count saturates at 2^CNT_WIDTH-1. Further errors still pulse err but the count does not wrap.
- step, hold and err are mutually exclusive. All three are 0 whenever bin_valid=0.

Test Plan (DATA_WIDTH=4, RELOCK=2 unless noted):
- Reset and first sample:
  - Stimulus: reset=1 for 2 cycles, then gray_valid with 0000.
  - Required: all outputs 0 during reset. The next cycle has bin_out=0000, bin_valid=1, step=hold=err=0, locked=1.
- Normal count:
  - Stimulus: from the first sample, feed 0001, 0011, 0010, 0110 on consecutive cycles.
  - Required: bin_out = 1, 2, 3, 4, each with step=1, locked=1, err_count=0.
- Wrap and idle gaps:
  - Stimulus: feed 1000 (bin 15), deassert gray_valid for 3 cycles, then feed 0000.
  - Required: bin_valid=0 and bin_out held at 1111 during the gap. The next sample gives bin_out=0000 with step=1, not err.
- Fault and relock:
  - Stimulus: prev=1 (0001), then feed 0010 (bin 3), 0110 (4), 0110 (4, hold), 0111 (5).
  - Required:
    - 0010: err=1, err_count=1, locked=0.
    - 0110: step=1, locked=0.
    - Repeated 0110: hold=1, locked=0.
    - 0111: step=1, locked=1.
- Error saturation:
  - Stimulus: CNT_WIDTH=2; feed 0000, 0011, 0000, 0011, 0000, 0011 (alternating bin 0 and 2).
  - Required: err pulses on every sample after the first. err_count goes 1, 2, 3, 3, 3. locked stays 0.
- Reset mid-operation:
  - Stimulus: while in FAULT with err_count=2, assert reset for 1 cycle together with gray_valid=1, then feed 1100 (bin 8).
  - Required: the reset-cycle sample is ignored and err_count=0. The 1100 sample gives bin_out=1000, no err, locked=1.
